// File: rtl/wide_add_pkg.sv
// Shared constants for the wide add/subtract sequencer.
package wide_add_pkg;
    localparam int SLICE_W       = 16;
    localparam int DEFAULT_WORDS = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/carry_select_adder.sv
// Existing 16-bit carry-select adder: the low byte ripples, and the high byte
// is precomputed for both carry values, then selected by the low carry.
module carry_select_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carryin,
    output logic [15:0] s,
    output logic        carryout
);
    logic [8:0] lo;
    logic [8:0] hi0;
    logic [8:0] hi1;

    assign lo  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, carryin};
    assign hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
    assign hi1 = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;

    assign s        = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
    assign carryout = lo[8] ? hi1[8] : hi0[8];
endmodule

// File: rtl/wide_add_sequencer.sv
// Wide add/subtract built from one 16-bit adder, one slice per cycle, LSB
// first, carry chained through a register. Valid/ready on both sides.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WORDS = DEFAULT_WORDS,
    parameter int IDXW  = 4,
    localparam int W    = SLICE_W * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf,
    output logic         busy
);
    logic [1:0]         state;
    logic [IDXW-1:0]    idx;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [W-1:0]       sum_reg;
    logic               carry_reg;
    logic               ovf_reg;

    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] s_sl;
    logic               c_out;
    logic               c_msb_in;
    logic               last;

    // Slice mux: current 16-bit window of each operand register.
    assign a_sl = a_reg[idx*SLICE_W +: SLICE_W];
    assign b_sl = b_reg[idx*SLICE_W +: SLICE_W];

    carry_select_adder u_csa (
        .a        (a_sl),
        .b        (b_sl),
        .carryin  (carry_reg),
        .s        (s_sl),
        .carryout (c_out)
    );

    // Carry into bit 15 recovered from the sum bit, leaving the adder untouched.
    assign c_msb_in = a_sl[SLICE_W-1] ^ b_sl[SLICE_W-1] ^ s_sl[SLICE_W-1];
    assign last     = (idx == IDXW'(WORDS - 1));

    // in_ready is forced low while reset is asserted.
    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_DONE);
    assign out_sum   = sum_reg;
    assign out_cout  = carry_reg;
    assign out_ovf   = ovf_reg;

    // Control FSM plus operand/result/carry datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtract becomes A + ~B + 1.
                        a_reg     <= in_a;
                        b_reg     <= in_sub ? ~in_b : in_b;
                        carry_reg <= in_sub ? 1'b1 : in_cin;
                        idx       <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_reg[idx*SLICE_W +: SLICE_W] <= s_sl;
                    carry_reg <= c_out;
                    idx       <= idx + IDXW'(1);
                    if (last) begin
                        ovf_reg <= c_msb_in ^ c_out;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle controller that time-multiplexes one existing 16-bit carry_select_adder to add or subtract wide operands (16*WORDS bits).
- Processes one 16-bit slice per cycle, LSB first, chaining the carry through a register.
- Sits in the SpMV accumulate path, where wide partial-sum updates arrive at low rate and a full-width adder is not justified.
- Valid/ready handshake on both the input and output sides.

Parameters:
- WORDS, 4, number of 16-bit slices; operand width W = 16*WORDS (default 64). Legal range 2..16.
- IDXW, 4, width of the slice index counter; must satisfy 2**IDXW >= WORDS.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands.
- in_a  input  W  operand A (unsigned or two's complement).
- in_b  input  W  operand B.
- in_cin  input  1  carry-in for add; ignored when in_sub=1.
- in_sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  result.
- out_cout  output  1  carry out of the MSB slice (for subtract: 1 = no borrow).
- out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; in_ready=0 while rst is high, 1 on the first cycle after release.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0; slice index=0; carry register=0.
  - An in-flight operation is discarded; no partial result is ever flagged valid.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready:
    - latch in_a into A_reg.
    - latch B_reg = in_sub ? ~in_b : in_b.
    - carry_reg = in_sub ? 1 : in_cin.
    - idx=0; go to RUN.
  - RUN: in_ready=0.
    - Each cycle drive the adder with a = A_reg[16*idx +: 16], b = B_reg[16*idx +: 16], carryin = carry_reg.
    - Write s into sum_reg[16*idx +: 16]; carry_reg <= carryout; idx <= idx+1.
    - On the MSB slice (idx==WORDS-1), also capture ovf = carry into bit 15 of that slice XOR carryout. Compute the carry into bit 15 as a[15]^b[15]^s[15]; the adder is not modified.
    - Then go to DONE.
  - DONE: out_valid=1; out_sum, out_cout and out_ovf are stable and held until out_valid&out_ready. On that cycle go to IDLE; out_valid=0 next cycle.
- Latency: operands accepted at edge k → out_valid high after edge k+WORDS. Default: 4 RUN cycles.
- Throughput: one operation per WORDS+2 cycles minimum (accept, WORDS RUN cycles, handshake). There is no accept in the same cycle as the output handshake; in_ready rises in IDLE only.
- Operand inputs are sampled only on the accept edge; later changes on in_a or in_b have no effect.
- Arithmetic is modulo 2**W. out_cout is the true (W+1)-th bit of A+B+cin. For subtract, {out_cout,out_sum} = A + (2**W - 1 - B) + 1.
- out_valid held with out_ready=0: the block stalls indefinitely in DONE with outputs unchanged and in_ready=0.
- in_valid high while not in IDLE: ignored, not queued.

Decomposition:
- Shared package wide_add_pkg:
  - SLICE_W=16.
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WORDS.
- One sub-module instance: the existing carry_select_adder (16-bit a/b/carryin/s/carryout), instantiated once, unmodified.
- The FSM, slice mux/demux, carry register and overflow logic stay in wide_add_sequencer.

Test Plan:
- Reset release, then A=64'h0000_0000_0000_0001, B=64'h0000_0000_0000_FFFF, cin=0, add → out_valid 4 cycles after accept; sum=64'h0000_0000_0001_0000, cout=0, ovf=0.
- Full carry ripple: A=64'hFFFF_FFFF_FFFF_FFFF, B=0, cin=1 → sum=0, cout=1, ovf=0.
- Subtract, signed overflow: A=64'h8000_0000_0000_0000, B=1, sub=1 → sum=64'h7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1. Subtract with borrow: A=3, B=5 → sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0, a concurrent in_valid is ignored. Release → in_ready=1 next cycle, and the next op completes correctly.
- Reset mid-RUN: assert rst after slice 2 → out_valid never asserts for that op; all outputs 0. A new op A=B=64'h1234_5678_9ABC_DEF0 gives sum=64'h2468_ACF1_3579_BDE0, cout=0.
- Random regression: 10,000 random A/B/cin/sub with random out_ready stalls → every result matches the reference model {cout,sum} and ovf, with zero mismatches counted.
